// File: rtl/extender.sv
// Immediate extender: rotated, load/store and branch immediates,
// registered onto ext_data one cycle after sampling.
module extender (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] instruction,
  input  logic [1:0]  imm_type,
  output logic [31:0] ext_data
);

  typedef enum logic [1:0] {
    IMM_ROT  = 2'b00,
    IMM_LS   = 2'b01,
    IMM_BR   = 2'b10,
    IMM_RSVD = 2'b11
  } imm_type_e;

  imm_type_e   sel;
  logic [7:0]  imm8;
  logic [3:0]  rot;
  logic [4:0]  shamt;
  logic [31:0] rot_src;
  logic [63:0] rot_dbl;
  logic [31:0] rot_imm;
  logic [31:0] ls_imm;
  logic [31:0] br_imm;
  logic [31:0] ext_data_d;
  logic [31:0] ext_data_q;

  assign sel   = imm_type_e'(imm_type);
  assign imm8  = instruction[7:0];
  assign rot   = instruction[11:8];
  assign shamt = {rot, 1'b0};

  // Doubled word makes the circular rotate a plain right shift.
  always_comb begin
    rot_src = {24'b0, imm8};
    rot_dbl = {rot_src, rot_src} >> shamt;
    rot_imm = rot_dbl[31:0];
  end

  assign ls_imm = {20'b0, instruction[11:0]};
  assign br_imm = {{6{instruction[23]}}, instruction, 2'b00};

  always_comb begin
    ext_data_d = 32'h0;
    unique case (sel)
      IMM_ROT:  ext_data_d = rot_imm;
      IMM_LS:   ext_data_d = ls_imm;
      IMM_BR:   ext_data_d = br_imm;
      IMM_RSVD: ext_data_d = 32'h0;
      default:  ext_data_d = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_data_q <= 32'h0;
    end else begin
      ext_data_q <= ext_data_d;
    end
  end

  assign ext_data = ext_data_q;

endmodule

// File: tb/tb_extender.sv
// Directed bench for extender: expected immediates are queued
// when stimulus is driven and checked one edge later.
module tb_extender;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [23:0] instruction = 24'hFFFFFF;
  logic [1:0]  imm_type = 2'b10;
  logic [31:0] ext_data;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_exp;

  extender dut (
    .clk(clk),
    .rst_n(rst_n),
    .instruction(instruction),
    .imm_type(imm_type),
    .ext_data(ext_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] exp);
    total++;
    assert (ext_data === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, ext_data, exp);
    end
  endtask

  task automatic pop_check(input string tag);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s: scoreboard empty", tag);
    end else begin
      e = exp_q.pop_front();
      last_exp = e;
      check(tag, e);
    end
  endtask

  task automatic step(input string tag, input logic [23:0] ins,
                      input logic [1:0] ty, input logic [31:0] exp);
    @(negedge clk);
    instruction = ins;
    imm_type = ty;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    pop_check(tag);
  endtask

  initial begin
    // Asynchronous reset, no clock edge yet.
    #1 rst_n = 1'b0;
    #2 check("reset_async", 32'h0);
    @(posedge clk); #1;
    check("reset_hold", 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(32'hFFFFFFFC);
    @(posedge clk); #1;
    pop_check("reset_release");

    step("br_0FFFFF", 24'h0FFFFF, 2'b10, 32'h003FFFFC);
    step("br_F0FFFF", 24'hF0FFFF, 2'b10, 32'hFFC3FFFC);
    step("br_FF0FFF", 24'hFF0FFF, 2'b10, 32'hFFFC3FFC);
    step("br_FFF0FF", 24'hFFF0FF, 2'b10, 32'hFFFFC3FC);
    step("br_FFFF0F", 24'hFFFF0F, 2'b10, 32'hFFFFFC3C);
    step("br_FFFFF0", 24'hFFFFF0, 2'b10, 32'hFFFFFFC0);
    step("br_pos",    24'h000001, 2'b10, 32'h00000004);

    step("rot_15",    24'h0FFFFF, 2'b00, 32'h000003FC);
    step("rot_0",     24'h0000AB, 2'b00, 32'h000000AB);
    step("rot_1",     24'h0001FF, 2'b00, 32'hC000003F);
    step("rot_hi_ign",24'hFFF0AB, 2'b00, 32'h000000AB);
    step("rot_4",     24'h000412, 2'b00, 32'h12000000);

    step("ls_FFF0FF", 24'hFFF0FF, 2'b01, 32'h000000FF);
    step("ls_000ABC", 24'h000ABC, 2'b01, 32'h00000ABC);
    step("ls_max",    24'hABCFFF, 2'b01, 32'h00000FFF);

    step("rsvd",      24'hFFFFFF, 2'b11, 32'h0);

    // Inputs change between edges: output holds.
    step("lat_load",  24'h000123, 2'b01, 32'h00000123);
    #2;
    instruction = 24'h800000;
    imm_type = 2'b10;
    exp_q.push_back(32'hFE000000);
    #1 check("lat_hold", last_exp);
    @(posedge clk); #1;
    pop_check("lat_next");

    // Reset pulse mid-cycle clears at once; no replay after release.
    step("mid_load",  24'h000ABC, 2'b01, 32'h00000ABC);
    #2 rst_n = 1'b0;
    #1 check("mid_clear", 32'h0);
    instruction = 24'h0001FF;
    imm_type = 2'b00;
    #1 rst_n = 1'b1;
    #1 check("mid_stay0", 32'h0);
    exp_q.push_back(32'hC000003F);
    @(posedge clk); #1;
    pop_check("mid_reload");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
